// File: rtl/histogram_cdf_reader_pkg.sv
// Shared histogram definitions: bin geometry, read-sweep states and the
// saturating accumulate used for the running CDF.
package histogram_cdf_reader_pkg;

  localparam int NUM_BINS_DEF = 256;
  localparam int COUNT_W_DEF  = 20;
  localparam int ADDR_W       = 8;
  localparam int SAT_W        = 32;

  typedef enum logic [2:0] {IDLE, READ, DRAIN, CLEAR, FINISH} state_t;

  // Bit SAT_W of the result flags saturation; the low bits hold the clamped sum,
  // where w is the width the sum must fit in.
  function automatic logic [SAT_W:0] satAdd(input logic [SAT_W-1:0] a,
                                            input logic [SAT_W-1:0] b,
                                            input int unsigned      w);
    logic [SAT_W:0] sum;
    logic [SAT_W:0] maxV;
    sum  = {1'b0, a} + {1'b0, b};
    maxV = ((SAT_W+1)'(1) << w) - (SAT_W+1)'(1);
    if (sum > maxV) return {1'b1, maxV[SAT_W-1:0]};
    return {1'b0, sum[SAT_W-1:0]};
  endfunction

endpackage

// File: rtl/histogram_cdf_reader_rd_pipe.sv
// Address/valid delay line matching the accumulator's read latency, so the
// returning count can be paired with the bin that requested it.
module hist_rd_pipe #(
  parameter int RD_LAT = 2,
  parameter int ADDR_W = 8
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iValid,
  input  logic [ADDR_W-1:0] iAddr,
  output logic              oValid,
  output logic [ADDR_W-1:0] oAddr
);

  logic [ADDR_W:0] stage [RD_LAT];

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      for (int i = 0; i < RD_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= {iValid, iAddr};
      for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign {oValid, oAddr} = stage[RD_LAT-1];

endmodule

// File: rtl/histogram_cdf_reader.sv
// Sweeps the accumulator's bins once per frame, streaming count and running CDF,
// then reports total, peak and overflow, optionally zeroing the accumulator RAM.
module histogram_cdf_reader
  import histogram_cdf_reader_pkg::*;
#(
  parameter int NUM_BINS = NUM_BINS_DEF,
  parameter int COUNT_W  = COUNT_W_DEF,
  parameter int CDF_W    = 20,
  parameter int RD_LAT   = 2
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iStart,
  input  logic               iClearAfter,
  output logic [ADDR_W-1:0]  oAddr,
  input  logic [COUNT_W-1:0] iCount,
  output logic               oClearRam,
  output logic               oBusy,
  output logic               oValid,
  output logic [ADDR_W-1:0]  oBin,
  output logic [COUNT_W-1:0] oCount,
  output logic [CDF_W-1:0]   oCdf,
  output logic               oDone,
  output logic [CDF_W-1:0]   oTotal,
  output logic [ADDR_W-1:0]  oPeakBin,
  output logic [COUNT_W-1:0] oPeakCount,
  output logic               oOverflow
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BINS - 1);

  state_t            state;
  logic              clearLatched;
  logic              issueVld;
  logic              pipeVld;
  logic [ADDR_W-1:0] pipeAddr;
  logic [SAT_W:0]    addRes;
  logic              startNow;
  logic              unusedAddBits;

  assign issueVld = (state == READ);
  // FINISH accepts a start as well so a done-coincident start is not lost.
  assign startNow = iStart && (state == IDLE || state == FINISH);
  assign addRes   = satAdd(SAT_W'(oCdf), SAT_W'(iCount), CDF_W);
  assign unusedAddBits = &{1'b0, addRes[SAT_W-1:CDF_W]};

  hist_rd_pipe #(.RD_LAT(RD_LAT), .ADDR_W(ADDR_W)) uRdPipe (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iValid (issueVld),
    .iAddr  (oAddr),
    .oValid (pipeVld),
    .oAddr  (pipeAddr)
  );

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state        <= IDLE;
      clearLatched <= 1'b0;
      oAddr        <= '0;
      oClearRam    <= 1'b0;
      oBusy        <= 1'b0;
      oValid       <= 1'b0;
      oBin         <= '0;
      oCount       <= '0;
      oCdf         <= '0;
      oDone        <= 1'b0;
      oTotal       <= '0;
      oPeakBin     <= '0;
      oPeakCount   <= '0;
      oOverflow    <= 1'b0;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: oAddr <= '0;
        READ: begin
          if (oAddr == LAST_ADDR) state <= DRAIN;
          else oAddr <= oAddr + ADDR_W'(1);
        end
        DRAIN: begin
          if (oValid && oBin == LAST_ADDR) begin
            if (clearLatched) begin
              state     <= CLEAR;
              oAddr     <= '0;
              oClearRam <= 1'b1;
            end else begin
              state  <= FINISH;
              oAddr  <= '0;
              oDone  <= 1'b1;
              oTotal <= oCdf;
            end
          end
        end
        CLEAR: begin
          if (oAddr == LAST_ADDR) begin
            state     <= FINISH;
            oAddr     <= '0;
            oClearRam <= 1'b0;
            oDone     <= 1'b1;
            oTotal    <= oCdf;
          end else begin
            oAddr <= oAddr + ADDR_W'(1);
          end
        end
        FINISH: begin
          state <= IDLE;
          oBusy <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (startNow) begin
        state        <= READ;
        oBusy        <= 1'b1;
        clearLatched <= iClearAfter;
        oAddr        <= '0;
        oCdf         <= '0;
        oTotal       <= '0;
        oPeakBin     <= '0;
        oPeakCount   <= '0;
        oOverflow    <= 1'b0;
      end

      // Output beat: count returns RD_LAT cycles after its address was issued.
      if (pipeVld) begin
        oValid <= 1'b1;
        oBin   <= pipeAddr;
        oCount <= iCount;
        oCdf   <= addRes[CDF_W-1:0];
        if (addRes[SAT_W]) oOverflow <= 1'b1;
        if (iCount > oPeakCount) begin
          oPeakBin   <= pipeAddr;
          oPeakCount <= iCount;
        end
      end else begin
        oValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_histogram_cdf_reader.sv
// Directed bench: a behavioural accumulator read port feeds a default reader and
// a narrow-CDF reader; sweeps are checked beat by beat and for end-of-frame results.
module tb_histogram_cdf_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iStart = 1'b0;
  logic        iClearAfter = 1'b0;
  logic [19:0] iCount;

  logic [7:0]  oAddr, oBin, oPeakBin;
  logic        oClearRam, oBusy, oValid, oDone, oOverflow;
  logic [19:0] oCount, oCdf, oTotal, oPeakCount;

  logic [7:0]  o2Addr, o2Bin, o2PeakBin;
  logic        o2ClearRam, o2Busy, o2Valid, o2Done, o2Overflow;
  logic [19:0] o2Count, o2PeakCount;
  logic [11:0] o2Cdf, o2Total;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [19:0] mem [256];
  logic [7:0]  d1 = 8'd0, d2 = 8'd0;

  int          beatCyc [256];
  logic [19:0] cdf1 [256];
  logic [11:0] cdf2 [256];
  int vcnt = 0, ccnt = 0, clrBad = 0, dcnt = 0;

  always #5 clk = ~clk;

  histogram_cdf_reader #(.NUM_BINS(256), .COUNT_W(20), .CDF_W(20), .RD_LAT(2)) dut (
    .iClk(clk), .iRst_n(rst_n), .iStart(iStart), .iClearAfter(iClearAfter),
    .oAddr(oAddr), .iCount(iCount), .oClearRam(oClearRam), .oBusy(oBusy),
    .oValid(oValid), .oBin(oBin), .oCount(oCount), .oCdf(oCdf), .oDone(oDone),
    .oTotal(oTotal), .oPeakBin(oPeakBin), .oPeakCount(oPeakCount), .oOverflow(oOverflow)
  );

  histogram_cdf_reader #(.NUM_BINS(256), .COUNT_W(20), .CDF_W(12), .RD_LAT(2)) dutNarrow (
    .iClk(clk), .iRst_n(rst_n), .iStart(iStart), .iClearAfter(iClearAfter),
    .oAddr(o2Addr), .iCount(iCount), .oClearRam(o2ClearRam), .oBusy(o2Busy),
    .oValid(o2Valid), .oBin(o2Bin), .oCount(o2Count), .oCdf(o2Cdf), .oDone(o2Done),
    .oTotal(o2Total), .oPeakBin(o2PeakBin), .oPeakCount(o2PeakCount), .oOverflow(o2Overflow)
  );

  // Accumulator read port model: count appears two cycles after the address.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    d1  <= oAddr;
    d2  <= d1;
  end
  assign iCount = mem[d2];

  always @(negedge clk) begin
    if (oValid === 1'b1) begin
      vcnt <= vcnt + 1;
      beatCyc[oBin] <= cyc;
      cdf1[oBin] <= oCdf;
    end
    if (o2Valid === 1'b1) cdf2[o2Bin] <= o2Cdf;
    if (oClearRam === 1'b1) begin
      ccnt <= ccnt + 1;
      if (oAddr !== 8'(ccnt % 256)) clrBad <= clrBad + 1;
    end
    if (oDone === 1'b1) dcnt <= dcnt + 1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic startSweep(input logic clr, output int s);
    iStart = 1'b1;
    iClearAfter = clr;
    s = cyc;
    tick();
    iStart = 1'b0;
    iClearAfter = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int dc);
    dc = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (oDone === 1'b1) begin
        dc = cyc;
        break;
      end
    end
  endtask

  task automatic checkContig(input string tag, input int s);
    int errs;
    errs = 0;
    for (int i = 0; i < 256; i++)
      if (beatCyc[i] != s + 4 + i) errs++;
    chk(tag, 64'(errs), 64'd0);
  endtask

  initial begin
    int s, s2, dc, v0, c0, d0, errs;

    for (int i = 0; i < 256; i++) begin
      mem[i] = 20'(i);
      beatCyc[i] = -1;
    end

    // Reset state
    repeat (3) tick();
    chk("rst_valid", 64'(oValid), 64'd0);
    chk("rst_busy", 64'(oBusy), 64'd0);
    chk("rst_done", 64'(oDone), 64'd0);
    chk("rst_clear", 64'(oClearRam), 64'd0);
    chk("rst_addr", 64'(oAddr), 64'd0);
    chk("rst_total", 64'(oTotal), 64'd0);
    rst_n = 1'b1;
    tick();

    // Ramp histogram, no clear
    v0 = vcnt; c0 = ccnt;
    startSweep(1'b0, s);
    chk("ramp_busy_after_start", 64'(oBusy), 64'd1);
    waitDone(600, dc);
    chk("ramp_done_cyc", 64'(dc), 64'(s + 260));
    chk("ramp_beats", 64'(vcnt - v0), 64'd256);
    checkContig("ramp_contig", s);
    errs = 0;
    for (int i = 0; i < 256; i++)
      if (cdf1[i] !== 20'(i * (i + 1) / 2)) errs++;
    chk("ramp_cdf_errs", 64'(errs), 64'd0);
    chk("ramp_cdf_255", 64'(cdf1[255]), 64'd32640);
    chk("ramp_total", 64'(oTotal), 64'd32640);
    chk("ramp_peak_bin", 64'(oPeakBin), 64'd255);
    chk("ramp_peak_cnt", 64'(oPeakCount), 64'd255);
    chk("ramp_ovf", 64'(oOverflow), 64'd0);
    chk("ramp_no_clear", 64'(ccnt - c0), 64'd0);
    chk("ramp_busy_at_done", 64'(oBusy), 64'd1);
    tick();
    chk("ramp_busy_after_done", 64'(oBusy), 64'd0);
    chk("ramp_done_pulse", 64'(oDone), 64'd0);
    chk("ramp_total_held", 64'(oTotal), 64'd32640);

    // Single large bin
    for (int i = 0; i < 256; i++) mem[i] = 20'd0;
    mem[100] = 20'd307200;
    startSweep(1'b0, s);
    waitDone(600, dc);
    chk("spike_done_cyc", 64'(dc), 64'(s + 260));
    chk("spike_cdf_99", 64'(cdf1[99]), 64'd0);
    chk("spike_cdf_100", 64'(cdf1[100]), 64'd307200);
    chk("spike_cdf_255", 64'(cdf1[255]), 64'd307200);
    chk("spike_peak_bin", 64'(oPeakBin), 64'd100);
    chk("spike_peak_cnt", 64'(oPeakCount), 64'd307200);
    chk("spike_ovf", 64'(oOverflow), 64'd0);

    // Flat histogram: narrow CDF saturates at bin 204
    for (int i = 0; i < 256; i++) mem[i] = 20'd20;
    startSweep(1'b0, s);
    waitDone(600, dc);
    chk("flat_done_cyc", 64'(dc), 64'(s + 260));
    chk("flat_n_cdf_203", 64'(cdf2[203]), 64'd4080);
    chk("flat_n_cdf_204", 64'(cdf2[204]), 64'd4095);
    chk("flat_n_cdf_255", 64'(cdf2[255]), 64'd4095);
    chk("flat_n_ovf", 64'(o2Overflow), 64'd1);
    chk("flat_n_total", 64'(o2Total), 64'd4095);
    chk("flat_total", 64'(oTotal), 64'd5120);
    chk("flat_ovf", 64'(oOverflow), 64'd0);
    chk("flat_peak_tie_bin", 64'(oPeakBin), 64'd0);

    // Tied peaks with clear sweep
    for (int i = 0; i < 256; i++) mem[i] = 20'd0;
    mem[7] = 20'd50;
    mem[9] = 20'd50;
    c0 = ccnt;
    startSweep(1'b1, s);
    chk("clr_ovf_cleared", 64'(o2Overflow), 64'd0);
    waitDone(900, dc);
    chk("clr_done_cyc", 64'(dc), 64'(s + 516));
    chk("clr_cycles", 64'(ccnt - c0), 64'd256);
    chk("clr_addr_errs", 64'(clrBad), 64'd0);
    chk("clr_peak_bin", 64'(oPeakBin), 64'd7);
    chk("clr_peak_cnt", 64'(oPeakCount), 64'd50);
    chk("clr_total", 64'(oTotal), 64'd100);
    chk("clr_ram_low_at_done", 64'(oClearRam), 64'd0);

    // Second start mid-sweep is ignored, including its clear request
    for (int i = 0; i < 256; i++) mem[i] = 20'(i);
    c0 = ccnt; v0 = vcnt;
    startSweep(1'b0, s);
    repeat (49) tick();
    iStart = 1'b1;
    iClearAfter = 1'b1;
    tick();
    iStart = 1'b0;
    iClearAfter = 1'b0;
    waitDone(900, dc);
    chk("dbl_done_cyc", 64'(dc), 64'(s + 260));
    chk("dbl_beats", 64'(vcnt - v0), 64'd256);
    checkContig("dbl_contig", s);
    chk("dbl_no_clear", 64'(ccnt - c0), 64'd0);
    chk("dbl_total", 64'(oTotal), 64'd32640);

    // Reset at beat 120
    startSweep(1'b0, s);
    while (cyc < s + 124) tick();
    rst_n = 1'b0;
    tick();
    chk("mrst_valid", 64'(oValid), 64'd0);
    chk("mrst_busy", 64'(oBusy), 64'd0);
    chk("mrst_clear", 64'(oClearRam), 64'd0);
    chk("mrst_cdf", 64'(oCdf), 64'd0);
    chk("mrst_peak", 64'(oPeakCount), 64'd0);
    chk("mrst_addr", 64'(oAddr), 64'd0);
    rst_n = 1'b1;
    d0 = dcnt;
    repeat (300) tick();
    chk("mrst_no_done", 64'(dcnt - d0), 64'd0);
    chk("mrst_idle_valid", 64'(oValid), 64'd0);

    // Fresh sweep, then a start coinciding with oDone
    startSweep(1'b0, s);
    waitDone(600, dc);
    chk("fresh_done_cyc", 64'(dc), 64'(s + 260));
    chk("fresh_total", 64'(oTotal), 64'd32640);
    startSweep(1'b0, s2);
    chk("b2b_busy", 64'(oBusy), 64'd1);
    chk("b2b_total_cleared", 64'(oTotal), 64'd0);
    waitDone(600, dc);
    chk("b2b_done_cyc", 64'(dc), 64'(s2 + 260));
    checkContig("b2b_contig", s2);
    chk("b2b_total", 64'(oTotal), 64'd32640);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
